// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// imem_load_ctrl : owns the instruction-memory port, streams a boot image in
//                  over valid/ready while stalling the core, then serves fetch.
// Optional checksum verification of the image: define IMEM_CKSUM_EN.
// Revision: 1.0
// ============================================================================
module imem_load_ctrl #(
  parameter int          DEPTH = 1024,
  parameter int          AW    = $clog2(DEPTH),
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_instr,
  output logic          fetch_misalign,
  output logic          core_stall,
  input  logic          ld_start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic [31:0]   ld_cksum,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   words_loaded,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [1:0]  S_LOAD = 2'd0;
  localparam logic [1:0]  S_DONE = 2'd1;
  localparam logic [1:0]  S_RUN  = 2'd2;
  localparam logic [1:0]  S_ERR  = 2'd3;

  localparam logic [AW:0] DEPTH_W    = (AW+1)'(DEPTH);
  localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH);

  logic [1:0]  r_state;
  logic [AW:0] r_wr_ptr;
  logic        r_load_err;

  logic w_run;
  logic w_hs;
  logic w_full;
  logic w_in_range;
  logic w_cksum_ok;

  assign w_run      = (r_state == S_RUN) & ~rst;
  assign ld_ready   = (r_state == S_LOAD) & ~ld_start & ~rst;
  assign w_hs       = ld_valid & ld_ready;
  assign w_full     = (r_wr_ptr == DEPTH_W);
  assign w_in_range = ({1'b0, fetch_addr} < BYTE_LIMIT);

`ifdef IMEM_CKSUM_EN
  logic [31:0] r_cksum;
  logic [31:0] w_sum_next;

  assign w_sum_next = r_cksum + ld_data;
  assign w_cksum_ok = (w_sum_next == ld_cksum);

  always_ff @(posedge clk) begin
    if (rst || ld_start) begin
      r_cksum <= '0;
    end else if (mem_we) begin
      r_cksum <= w_sum_next;
    end
  end
`else
  logic unused_cksum;

  assign unused_cksum = ^ld_cksum;
  assign w_cksum_ok   = 1'b1;
`endif

  // Overflow beats are consumed but dropped so the loader never deadlocks.
  assign mem_we         = w_hs & ~w_full;
  assign mem_wdata      = ld_data;
  assign mem_addr       = w_run ? fetch_addr[AW+1:2] : r_wr_ptr[AW-1:0];
  assign fetch_instr    = (w_run && w_in_range) ? mem_rdata : NOP;
  assign fetch_misalign = w_run & (fetch_addr[1:0] != 2'b00);
  assign core_stall     = ~w_run;
  assign load_done      = (r_state == S_DONE) & ~rst;
  assign load_err       = r_load_err;
  assign words_loaded   = r_wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || ld_start) begin
      r_state    <= S_LOAD;
      r_wr_ptr   <= '0;
      r_load_err <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_hs) begin
            if (w_full) begin
              r_load_err <= 1'b1;
              r_state    <= S_ERR;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              if (ld_last) begin
                if (w_cksum_ok) begin
                  r_state <= S_DONE;
                end else begin
                  r_load_err <= 1'b1;
                  r_state    <= S_ERR;
                end
              end
            end
          end
        end
        S_DONE:  r_state <= S_RUN;
        default: r_state <= r_state;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// Bench for imem_load_ctrl (DEPTH=8): directed load/run/reload/overflow
// scenarios against a per-cycle expectation model plus literal spot checks.
module tb_imem_load_ctrl;

  localparam int          DEPTH = 8;
  localparam int          AW    = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_instr;
  logic          fetch_misalign;
  logic          core_stall;
  logic          ld_start;
  logic          ld_valid;
  logic          ld_ready;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic [31:0]   ld_cksum;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0]   tb_mem [0:DEPTH-1];

  imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
    .clk(clk), .rst(rst),
    .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
    .fetch_misalign(fetch_misalign), .core_stall(core_stall),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .ld_cksum(ld_cksum),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Instruction memory: combinational read, synchronous write
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;
  assign mem_rdata = tb_mem[mem_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expectation model: phase of the image lifecycle plus the expected image
  localparam int M_LOADING = 0, M_DONE = 1, M_RUN = 2, M_ERR = 3;
  int          m_phase;
  int          m_count;
  logic        m_err;
  logic [31:0] m_sum;
  logic [31:0] m_image   [0:DEPTH-1];
  logic        m_written [0:DEPTH-1];
  bit          model_live = 1'b0;

  always @(negedge clk) begin
    if (model_live) begin
      logic accept, exp_we, running;
      int   idx;
      running = (m_phase == M_RUN) && !rst;
      accept  = (m_phase == M_LOADING) && !ld_start && !rst;
      exp_we  = accept && ld_valid && (m_count < DEPTH);
      chk("ld_ready", ld_ready, accept);
      chk("mem_we", mem_we, exp_we);
      chk("core_stall", core_stall, !running);
      chk("load_done", load_done, (m_phase == M_DONE) && !rst);
      chk("load_err", load_err, m_err);
      chk("words_loaded", words_loaded, m_count);
      chk("fetch_misalign", fetch_misalign, running && (fetch_addr[1:0] != 2'b00));
      if (exp_we) begin
        chk("mem_addr_wr", mem_addr, m_count);
        chk("mem_wdata", mem_wdata, ld_data);
      end
      if (running && fetch_addr < 4 * DEPTH) begin
        idx = int'(fetch_addr >> 2);
        chk("mem_addr_rd", mem_addr, idx);
        if (m_written[idx]) chk("fetch_instr", fetch_instr, m_image[idx]);
      end else begin
        chk("fetch_instr_nop", fetch_instr, NOP);
      end

      if (rst || ld_start) begin
        m_phase = M_LOADING; m_count = 0; m_err = 1'b0; m_sum = '0;
      end else if (m_phase == M_LOADING && ld_valid) begin
        if (m_count == DEPTH) begin
          m_err = 1'b1; m_phase = M_ERR;
        end else begin
          m_image[m_count]   = ld_data;
          m_written[m_count] = 1'b1;
          m_count++;
          m_sum += ld_data;
          if (ld_last) begin
`ifdef IMEM_CKSUM_EN
            if (m_sum != ld_cksum) begin m_err = 1'b1; m_phase = M_ERR; end
            else m_phase = M_DONE;
`else
            m_phase = M_DONE;
`endif
          end
        end
      end else if (m_phase == M_DONE) begin
        m_phase = M_RUN;
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    ld_valid = v; ld_data = d; ld_last = l;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1; ld_valid = 1'b0;
    @(posedge clk); #1;
    ld_start = 1'b0;
  endtask

  logic [31:0] boot [0:3];

  initial begin
    boot[0] = 32'h0020_0193; boot[1] = 32'h4041_8333;
    boot[2] = 32'h00f3_f413; boot[3] = 32'h0000_0013;
    for (int i = 0; i < DEPTH; i++) m_written[i] = 1'b0;
    rst = 1'b1; fetch_addr = '0; ld_start = 1'b0; ld_valid = 1'b0;
    ld_data = '0; ld_last = 1'b0; ld_cksum = '0;
    @(posedge clk); #1;
    m_phase = M_LOADING; m_count = 0; m_err = 1'b0; m_sum = '0;
    model_live = 1'b1;
    @(negedge clk);
    chk("rst_stall", core_stall, 1'b1);
    chk("rst_ready", ld_ready, 1'b0);
    chk("rst_words", words_loaded, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1 boot image
    for (int i = 0; i < 4; i++) drive(1'b1, boot[i], i == 3);
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    chk("t1_done_pulse", load_done, 1'b1);
    chk("t1_words", words_loaded, 4);
    chk("t1_mem1", tb_mem[1], 32'h4041_8333);
    @(posedge clk); #1;
    fetch_addr = 32'd8;
    @(negedge clk);
    chk("t1_stall", core_stall, 1'b0);
    chk("t1_fetch8", fetch_instr, 32'h00f3_f413);
    chk("t1_done_gone", load_done, 1'b0);
    @(posedge clk); #1;
    fetch_addr = 32'h1002;
    @(negedge clk);
    chk("misalign", fetch_misalign, 1'b1);
    @(posedge clk); #1;
    fetch_addr = 4 * DEPTH;
    @(negedge clk);
    chk("oob_nop", fetch_instr, NOP);
    @(posedge clk); #1;
    fetch_addr = 32'd4;

    // T5 reload with a pending beat, then T2 gapped stream
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 32'hdead_beef;
    @(negedge clk);
    chk("t5_no_accept", mem_we, 1'b0);
    chk("t5_still_run", core_stall, 1'b0);
    @(posedge clk); #1;
    ld_start = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("t5_stall_next", core_stall, 1'b1);
    chk("t5_words0", words_loaded, 0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'ha000_0001, 1'b0);
    drive(1'b0, 32'hffff_ffff, 1'b1);
    drive(1'b1, 32'ha000_0002, 1'b0);
    drive(1'b0, 32'hffff_ffff, 1'b0);
    drive(1'b1, 32'ha000_0003, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    chk("t2_words", words_loaded, 3);
    chk("t2_mem0", tb_mem[0], 32'ha000_0001);
    chk("t2_mem2", tb_mem[2], 32'ha000_0003);
    chk("t2_mem3_kept", tb_mem[3], 32'h0000_0013);
    repeat (2) begin @(posedge clk); #1; end

    // T3 overflow: nine beats, none last
    pulse_start();
    for (int i = 0; i < 9; i++) drive(1'b1, 32'hb000_0000 + i, 1'b0);
    ld_valid = 1'b0;
    fetch_addr = 32'd0;
    @(negedge clk);
    chk("t3_err", load_err, 1'b1);
    chk("t3_words", words_loaded, 8);
    chk("t3_stall", core_stall, 1'b1);
    chk("t3_nop", fetch_instr, NOP);
    chk("t3_mem7", tb_mem[7], 32'hb000_0007);
    drive(1'b1, 32'h1234_5678, 1'b1);
    ld_valid = 1'b0;

    // T4 exact fill
    pulse_start();
    for (int i = 0; i < 8; i++) drive(1'b1, 32'hc000_0000 + i, i == 7);
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    chk("t4_done", load_done, 1'b1);
    chk("t4_noerr", load_err, 1'b0);
    repeat (2) begin @(posedge clk); #1; end

    // rst during a load
    pulse_start();
    drive(1'b1, 32'hd000_0000, 1'b0);
    drive(1'b1, 32'hd000_0001, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", mem_we, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_words", words_loaded, 0);
    chk("rst_mid_ready", ld_ready, 1'b1);
    chk("rst_mid_kept", tb_mem[1], 32'hd000_0001);

    // T6 checksum
    pulse_start();
    ld_cksum = 32'd6;
    for (int i = 1; i <= 3; i++) drive(1'b1, i, i == 3);
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    chk("t6_good_done", load_done, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    pulse_start();
    ld_cksum = 32'd7;
    for (int i = 1; i <= 3; i++) drive(1'b1, i, i == 3);
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
`ifdef IMEM_CKSUM_EN
    chk("t6_bad_nodone", load_done, 1'b0);
    chk("t6_bad_err", load_err, 1'b1);
`else
    chk("t6_ignored_done", load_done, 1'b1);
    chk("t6_ignored_err", load_err, 1'b0);
`endif
    repeat (3) begin @(posedge clk); #1; end

    model_live = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
